// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_pkg
//  Purpose  : Shared types and constants for the instruction-memory loader.
//  Revision : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

  localparam int LOADER_N       = 32;
  localparam int BYTES_PER_WORD = LOADER_N / 8;

  function automatic int idx_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : byte_packer
//  Purpose  : Assembles little-endian bytes into one N-bit word.
//  Revision : 1.0  initial release
// ============================================================================
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int N = LOADER_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [7:0]   byte_in,
  input  logic         clear,
  output logic [N-1:0] word_out,
  output logic         word_full
);

  localparam int                 c_BYTES = N / 8;
  localparam int                 c_IDX_W = idx_width(c_BYTES);
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(c_BYTES - 1);

  logic [c_IDX_W-1:0] r_idx;
  logic [N-1:0]       r_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (clear) begin
      r_idx <= '0;
    end else if (push) begin
      for (int b = 0; b < c_BYTES; b++) begin
        if (r_idx == c_IDX_W'(b)) r_word[b*8 +: 8] <= byte_in;
      end
      r_idx <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // High while the next pushed byte is the one that completes the word.
  assign word_full = (r_idx == c_LAST);
  assign word_out  = r_word;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Loads a checksummed byte-stream image into instruction RAM and
//             holds the CPU in reset until a valid image is present.
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N      = LOADER_N,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [N-1:0]      wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic              w_xfer;
  logic              w_hdr;
  logic              w_push;
  logic              w_csum_ok;
  logic              w_csum_bad;
  logic              w_last_word;
  logic              w_word_full;
  logic [N-1:0]      w_word;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_acc;
  logic              r_hold;
  logic              r_done;
  logic              r_err;

  assign in_ready = (r_state != WRITE);
  assign w_xfer   = in_valid & in_ready;
  // A count of zero wraps so that the 256th word (address 255) is the last.
  assign w_last_word = (r_waddr == r_count - 1'b1);

  byte_packer #(.N(N)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .byte_in   (in_data),
    .clear     (w_hdr),
    .word_out  (w_word),
    .word_full (w_word_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_hdr      = 1'b0;
    w_push     = 1'b0;
    w_csum_ok  = 1'b0;
    w_csum_bad = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (w_xfer) begin
          w_hdr  = 1'b1;
          w_next = DATA;
        end
      end
      DATA: begin
        if (w_xfer) begin
          w_push = 1'b1;
          if (w_word_full) w_next = WRITE;
        end
      end
      WRITE: w_next = w_last_word ? CSUM : DATA;
      CSUM: begin
        if (w_xfer) begin
          if (in_data == r_acc) begin
            w_csum_ok = 1'b1;
            w_next    = DONE;
          end else begin
            w_csum_bad = 1'b1;
            w_next     = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_waddr <= '0;
      r_acc   <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_csum_ok;
      if (w_hdr) begin
        r_count <= ADDR_W'(in_data);
        r_waddr <= '0;
        r_acc   <= '0;
        r_err   <= 1'b0;
        r_hold  <= 1'b1;
      end
      if (w_push)            r_acc   <= r_acc ^ in_data;
      if (r_state == WRITE)  r_waddr <= r_waddr + 1'b1;
      if (w_csum_ok)         r_hold  <= 1'b0;
      if (w_csum_bad)        r_err   <= 1'b1;
    end
  end

  assign we        = (r_state == WRITE);
  assign waddr     = r_waddr;
  assign wdata     = w_word;
  assign cpu_hold  = r_hold;
  assign load_done = r_done;
  assign load_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader with a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, we, cpu_hold, load_done, load_err;
  logic [7:0]  waddr;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame_q[$];
  logic [31:0] exp_words[$];
  bit          exp_ok;
  int          waits_q[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.N(32), .ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      wr_addr_q.push_back(waddr);
      wr_data_q.push_back(wdata);
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Present one byte and return after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout got in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input bit gaps);
    int w;
    waits_q.delete();
    foreach (frame_q[i]) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send_byte(frame_q[i], w);
      waits_q.push_back(w);
    end
    in_valid = 1'b0;
  endtask

  task automatic make_frame(input int n, input bit ok, input bit incr);
    logic [7:0] x;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(n));
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = incr ? 8'(i) : 8'($urandom);
      frame_q.push_back(b);
      x ^= b;
    end
    frame_q.push_back(ok ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  // Reference model: parse the frame as the host defines it.
  task automatic build_expected();
    int         n;
    logic [7:0] x;
    n = (frame_q[0] == 8'd0) ? 256 : int'(frame_q[0]);
    exp_words.delete();
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_words.push_back({frame_q[4*i+4], frame_q[4*i+3], frame_q[4*i+2], frame_q[4*i+1]});
      for (int k = 1; k <= 4; k++) x ^= frame_q[4*i+k];
    end
    exp_ok = (frame_q[frame_q.size()-1] == x);
  endtask

  task automatic test_reset();
    idle(2);
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    checks++; if (we !== 1'b0)        begin errors++; $display("FAIL reset_we got %b required 0", we); end
    checks++; if (waddr !== 8'h00)    begin errors++; $display("FAIL reset_waddr got %h required 00", waddr); end
    checks++; if (wdata !== 32'h0)    begin errors++; $display("FAIL reset_wdata got %h required 0", wdata); end
    checks++; if (cpu_hold !== 1'b1)  begin errors++; $display("FAIL reset_cpu_hold got %b required 1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b required 0", load_done); end
    checks++; if (load_err !== 1'b0)  begin errors++; $display("FAIL reset_load_err got %b required 0", load_err); end
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_good_frame(input logic [7:0] csum);
    logic [31:0] want [3];
    want[0] = 32'hf8000001; want[1] = 32'hf8008002; want[2] = 32'hf8000203;
    frame_q = '{8'h03, 8'h01, 8'h00, 8'h00, 8'hf8, 8'h02, 8'h80, 8'h00, 8'hf8,
                8'h03, 8'h02, 8'h00, 8'hf8, csum};
    clear_writes();
    send_frame(1'b1);
    checks++; if (load_done !== (csum == 8'h7a)) begin errors++; $display("FAIL frame_load_done csum=%h got %b required %b", csum, load_done, csum == 8'h7a); end
    checks++; if (cpu_hold !== (csum != 8'h7a))  begin errors++; $display("FAIL frame_cpu_hold csum=%h got %b required %b", csum, cpu_hold, csum != 8'h7a); end
    checks++; if (load_err !== (csum != 8'h7a))  begin errors++; $display("FAIL frame_load_err csum=%h got %b required %b", csum, load_err, csum != 8'h7a); end
    idle(2);
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse got %b required 0", load_done); end
    checks++;
    if (wr_addr_q.size() != 3) begin
      errors++; $display("FAIL frame_write_count got %0d required 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== want[i]) begin
          errors++; $display("FAIL frame_write%0d got %h@%h required %h@%h", i, wr_data_q[i], wr_addr_q[i], want[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_full_image();
    make_frame(256, 1'b1, 1'b1);
    build_expected();
    clear_writes();
    send_frame(1'b0);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL full_load_done got %b required 1", load_done); end
    idle(2);
    checks++; if (waddr !== 8'h00) begin errors++; $display("FAIL full_waddr_wrap got %h required 00", waddr); end
    checks++;
    if (wr_addr_q.size() != 256) begin
      errors++; $display("FAIL full_write_count got %0d required 256", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== exp_words[i]) begin
          errors++; $display("FAIL full_write%0d got %h@%h required %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_words[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int want;
    make_frame(3, 1'b1, 1'b0);
    build_expected();
    clear_writes();
    send_frame(1'b0);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL b2b_load_done got %b required 1", load_done); end
    foreach (waits_q[j]) begin
      want = (j >= 2 && ((j - 1) % 4) == 0) ? 1 : 0;
      checks++;
      if (waits_q[j] != want) begin
        errors++; $display("FAIL b2b_stall_byte%0d got %0d required %0d", j, waits_q[j], want);
      end
    end
    idle(2);
    checks++;
    if (wr_data_q.size() != 3 || wr_data_q[0] !== exp_words[0] || wr_data_q[1] !== exp_words[1] || wr_data_q[2] !== exp_words[2]) begin
      errors++; $display("FAIL b2b_words got %0d writes required 3 matching model", wr_data_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    clear_writes();
    send_byte(8'h02, w);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), w);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || we !== 1'b0 || waddr !== 8'h00 || wdata !== 32'h0 ||
        cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b required 1 0 00 0 1 0 0",
                         in_ready, we, waddr, wdata, cpu_hold, load_done, load_err);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    idle(3);
    checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL midreset_write_count got %0d required 1", wr_addr_q.size()); end
    make_frame(1, 1'b1, 1'b0);
    build_expected();
    clear_writes();
    send_frame(1'b1);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL midreset_reload_done got %b required 1", load_done); end
    idle(2);
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== exp_words[0]) begin
      errors++; $display("FAIL midreset_reload_write got %0d writes required 1 at 00 data %h", wr_addr_q.size(), exp_words[0]);
    end
  endtask

  task automatic test_reload();
    int w;
    make_frame(2, 1'b0, 1'b0);
    send_frame(1'b1);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL reload_err_set got %b required 1", load_err); end
    make_frame(1, 1'b1, 1'b0);
    send_byte(frame_q[0], w);
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reload_err_clear got %b required 0", load_err); end
    for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i], w);
    in_valid = 1'b0;
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reload_hold_release got %b required 0", cpu_hold); end
    idle(2);
    make_frame(1, 1'b1, 1'b0);
    build_expected();
    clear_writes();
    send_byte(frame_q[0], w);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reload_hold_on_header got %b required 1", cpu_hold); end
    for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i], w);
    in_valid = 1'b0;
    idle(2);
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== exp_words[0]) begin
      errors++; $display("FAIL reload_write got %0d writes required 1 at 00 data %h", wr_addr_q.size(), exp_words[0]);
    end
  endtask

  task automatic test_random_frames();
    for (int r = 0; r < 8; r++) begin
      make_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
      build_expected();
      clear_writes();
      send_frame(1'b1);
      checks++; if (load_done !== exp_ok)  begin errors++; $display("FAIL rand%0d_done got %b required %b", r, load_done, exp_ok); end
      checks++; if (cpu_hold !== !exp_ok)  begin errors++; $display("FAIL rand%0d_hold got %b required %b", r, cpu_hold, !exp_ok); end
      checks++; if (load_err !== !exp_ok)  begin errors++; $display("FAIL rand%0d_err got %b required %b", r, load_err, !exp_ok); end
      idle($urandom_range(2, 4));
      checks++;
      if (wr_addr_q.size() != exp_words.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d required %0d", r, wr_addr_q.size(), exp_words.size());
      end else begin
        foreach (exp_words[i]) begin
          checks++;
          if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== exp_words[i]) begin
            errors++; $display("FAIL rand%0d_write%0d got %h@%h required %h@%h", r, i, wr_data_q[i], wr_addr_q[i], exp_words[i], 8'(i));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame(8'h7a);
    test_good_frame(8'h7b);
    test_full_image();
    test_back_to_back();
    test_reset_mid_frame();
    test_reload();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
